// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and status controller for a dual-port RAM
// used as a synchronous FIFO. No data passes through this block; it only
// produces RAM strobes/addresses and FIFO status.
//
// DEPTH must be a power of two equal to 2**AW, no larger than 32, and
// RAM_AW must be at least AW.

module fifo_ctrl #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int RAM_AW   = 5,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic              clr_err,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic              ram_re,
    output logic [RAM_AW-1:0] ram_raddr,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic        rd_valid_q, rd_valid_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    logic        full_w;
    logic        empty_w;
    logic        wr_acc;
    logic        rd_acc;

    // Status flags come only from the registered occupancy, never from requests.
    always_comb begin
        full_w       = (count_q == DEPTH_C);
        empty_w      = (count_q == '0);
        full         = full_w;
        empty        = empty_w;
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);
        count        = count_q;
        rd_valid     = rd_valid_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    // Request acceptance; reset and flush block every RAM access.
    always_comb begin
        wr_acc = rst_n & push & ~full_w  & ~flush;
        rd_acc = rst_n & pop  & ~empty_w & ~flush;
    end

    // RAM strobes and addresses; addresses held at 0 while in reset.
    always_comb begin
        ram_we    = wr_acc;
        ram_re    = rd_acc;
        ram_waddr = rst_n ? RAM_AW'(wr_ptr_q[AW-1:0]) : '0;
        ram_raddr = rst_n ? RAM_AW'(rd_ptr_q[AW-1:0]) : '0;
    end

    // Next pointer / occupancy / read-valid state; flush clears all of them.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_acc;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ONE_C;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + ONE_C;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // Sticky error flags: a new error in the same cycle as clr_err is kept.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (push & full_w & ~flush) begin
            overflow_d = 1'b1;
        end
        if (pop & empty_w & ~flush) begin
            underflow_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller that sequences the 16 x 8 dual-port `RAM` block as a synchronous FIFO. It accepts push/pop requests, drives the RAM write and read strobes and addresses, and tracks occupancy. It also produces full/empty/threshold flags and sticky error status. The data path (`write_data` to `read_data`) runs directly through the RAM. This block carries no data, only control and addressing.

## Interface
- `DEPTH`, 16: number of RAM entries; must be a power of two and ≤ 32.
- `AW`, 4: log2(DEPTH); pointer width is AW+1 (wrap bit).
- `RAM_AW`, 5: width of the RAM address ports; upper RAM_AW-AW bits driven 0.
- `AF_LEVEL`, 12: `almost_full` asserts when count ≥ AF_LEVEL.
- `AE_LEVEL`, 2: `almost_empty` asserts when count ≤ AE_LEVEL.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `push`  in  1  write request; data presented to RAM `write_data` in the same cycle.
- `pop`  in  1  read request.
- `flush`  in  1  synchronous clear of pointers/count; keeps error flags.
- `clr_err`  in  1  clears `overflow`/`underflow`.
- `ram_we`  out  1  to RAM `write_enable`.
- `ram_waddr`  out  RAM_AW  to RAM `write_addr`.
- `ram_re`  out  1  to RAM `read_enable`.
- `ram_raddr`  out  RAM_AW  to RAM `read_addr`.
- `rd_valid`  out  1  RAM `read_data` holds popped word this cycle.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  status.
- `count`  out  AW+1  occupancy, 0..DEPTH.
- `overflow`, `underflow`  out  1 each  sticky error flags.

## Operation
- State registers: `wr_ptr`, `rd_ptr` (AW+1 bits each), `count` (AW+1), `rd_valid`, `overflow`, `underflow`.
- Flags are decoded from the registered `count`: full = (count==DEPTH), empty = (count==0). Flags never look at the current cycle's requests.
- Write accepted (`wr_acc`) = push & ~full & ~flush. Read accepted (`rd_acc`) = pop & ~empty & ~flush.
- `ram_we` = wr_acc and `ram_re` = rd_acc. Both are combinational from registered state and inputs.
- `ram_waddr` = {0, wr_ptr[AW-1:0]} and `ram_raddr` = {0, rd_ptr[AW-1:0]}.
- On wr_acc, wr_ptr increments by 1 modulo 2^(AW+1). On rd_acc, rd_ptr does the same.
- count next = count + wr_acc − rd_acc.
- Push and pop together with 0 < count < DEPTH: both accepted, count unchanged.
- Push and pop together when full: pop is accepted and push is rejected. Push sets `overflow`; count goes to DEPTH−1.
- Push and pop together when empty: push is accepted and pop is rejected (no fall-through). Pop sets `underflow`; count goes to 1.
- `overflow` sets on push & full & ~flush. `underflow` sets on pop & empty & ~flush. Both hold until `clr_err` or reset. If a set condition and `clr_err` occur in the same cycle, the set wins.
- `flush`: wr_ptr, rd_ptr, count and rd_valid go to 0 next cycle, and ram_we/ram_re are forced 0 that cycle. Flush has priority over push and pop. Error flags are unaffected.
- Pointer invariant: count == (wr_ptr − rd_ptr) mod 2^(AW+1) at all times.

## Timing
- Reset (rst_n=0 at a rising edge): pointers, count, rd_valid, overflow and underflow go to 0. While in reset, ram_we and ram_re are 0 and ram addresses are 0. Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0.
- Pushed data is written to the RAM at the edge ending the push cycle. It is poppable from the next cycle onward; count and empty update at that same edge.
- Pop latency is 1 cycle. The RAM registers `read_data` at the edge ending the rd_acc cycle, and `rd_valid` is asserted for exactly the following cycle.
- Back-to-back pops give one word per cycle with rd_valid continuously high.
- rd_valid is cleared in the cycle after a flush or reset, even if a pop was accepted just before.
- Reset asserted mid-operation discards all contents. The RAM array itself is not cleared.
- All outputs except ram_we, ram_re, ram_waddr and ram_raddr are registered or decoded from registers only.

## Test plan
- Reset, then 16 consecutive pushes of 0x00..0x0F: full rises after the 16th edge with count=16. almost_full rises when count reaches 12. ram_waddr sequence is 0..15.
- A 17th push while full: ram_we=0, overflow=1 and stays high, count stays 16. Pulse clr_err: overflow=0.
- 16 pops from full: read_data = 0x00..0x0F with rd_valid high for 16 consecutive cycles, each one cycle after its pop. empty=1 at the end, and pop while empty sets underflow.
- Pointer wrap: after 10 push/pop pairs, push 12 more. Waddr wraps from 15 to 0, count=12, and the data reads back in order.
- Simultaneous push+pop at count=16 (count→15, overflow=1), at count=0 (count→1, underflow=1, no rd_valid next cycle), and at count=5 (count stays 5).
- Flush at count=7 with push+pop asserted: next cycle count=0, empty=1, rd_valid=0, ram_we/ram_re=0 in the flush cycle. Also assert rst_n=0 mid-stream: all outputs return to their reset values after one edge.
